// File: rtl/uart_debug_master.sv
// uart_debug_master: UART-driven 32-bit bus initiator for program load and peek/poke.
// Define DBG_TIMEOUT_EN to abandon a partial packet after TIMEOUT_CYCLES idle cycles.
module uart_debug_master #(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        RST,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    input  logic        txBusy,
    output logic [7:0]  txData,
    output logic        txWE,
    output logic [31:0] vaddr,
    output logic [31:0] data,
    output logic [3:0]  byteena,
    output logic        memWE,
    input  logic        memWait,
    input  logic [31:0] q,
    output logic        active
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, SEND, WAITHI, WAITLO} state_t;
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d, left_q, left_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0] addr_ins, wdata_ins;
    logic [15:0] lat_q, lat_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_we_q, tx_we_d, mem_we_q, mem_we_d, active_q, active_d;
    logic [31:0] vaddr_q, vaddr_d, data_q, data_d;
    logic [3:0]  byteena_q, byteena_d;
`ifdef DBG_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    assign txData  = tx_data_q;
    assign txWE    = tx_we_q;
    assign vaddr   = vaddr_q;
    assign data    = data_q;
    assign byteena = byteena_q;
    assign memWE   = mem_we_q;
    assign active  = active_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        left_d    = left_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        lat_d     = lat_q;
        tx_data_d = tx_data_q;
        tx_we_d   = 1'b0;
        mem_we_d  = mem_we_q;
        active_d  = active_q;
        vaddr_d   = vaddr_q;
        data_d    = data_q;
        byteena_d = byteena_q;
        addr_ins  = addr_q;
        addr_ins[{idx_q, 3'b000} +: 8] = rxData;
        wdata_ins = wdata_q;
        wdata_ins[{idx_q, 3'b000} +: 8] = rxData;
        case (state_q)
            IDLE: if (rxValid) begin
                active_d = 1'b1;
                idx_d    = 2'd0;
                is_wr_d  = rxData == 8'h57;
                if (rxData == 8'h57 || rxData == 8'h52) begin
                    state_d = ADDR;
                end else begin
                    buf_d   = 32'h3F;
                    left_d  = 2'd0;
                    state_d = SEND;
                end
            end
            ADDR: if (rxValid) begin
                addr_d = addr_ins;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (is_wr_q) begin
                        state_d = DATA;
                    end else begin
                        state_d   = MEM;
                        vaddr_d   = addr_ins;
                        byteena_d = 4'hF;
                        lat_d     = 16'd0;
                    end
                end
            end
            DATA: if (rxValid) begin
                wdata_d = wdata_ins;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d   = MEM;
                    vaddr_d   = addr_q;
                    data_d    = wdata_ins;
                    byteena_d = 4'hF;
                    mem_we_d  = 1'b1;
                end
            end
            MEM: begin
                if (is_wr_q) begin
                    if (!memWait) begin
                        mem_we_d  = 1'b0;
                        byteena_d = 4'h0;
                        buf_d     = 32'h4B;
                        left_d    = 2'd0;
                        state_d   = SEND;
                    end
                end else if (lat_q != 16'(READ_LATENCY)) begin
                    lat_d = lat_q + 16'd1;
                end else if (!memWait) begin
                    byteena_d = 4'h0;
                    buf_d     = q;
                    left_d    = 2'd3;
                    state_d   = SEND;
                end
            end
            SEND: if (!txBusy) begin
                tx_data_d = buf_q[7:0];
                tx_we_d   = 1'b1;
                state_d   = WAITHI;
            end
            WAITHI: if (txBusy) state_d = WAITLO;
            WAITLO: if (!txBusy) begin
                if (left_q == 2'd0) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end else begin
                    buf_d   = buf_q >> 8;
                    left_d  = left_q - 2'd1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DBG_TIMEOUT_EN
        // Counter only runs while a packet is half-received; any accepted byte restarts it.
        tmo_d = 32'd0;
        if ((state_q == ADDR || state_q == DATA) && !rxValid) begin
            if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                buf_d   = 32'h3F;
                left_d  = 2'd0;
                idx_d   = 2'd0;
                state_d = SEND;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            left_q    <= 2'd0;
            is_wr_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            buf_q     <= 32'd0;
            lat_q     <= 16'd0;
            tx_data_q <= 8'd0;
            tx_we_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            active_q  <= 1'b0;
            vaddr_q   <= 32'd0;
            data_q    <= 32'd0;
            byteena_q <= 4'h0;
`ifdef DBG_TIMEOUT_EN
            tmo_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            left_q    <= left_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
            lat_q     <= lat_d;
            tx_data_q <= tx_data_d;
            tx_we_q   <= tx_we_d;
            mem_we_q  <= mem_we_d;
            active_q  <= active_d;
            vaddr_q   <= vaddr_d;
            data_q    <= data_d;
            byteena_q <= byteena_d;
`ifdef DBG_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end
endmodule
